// File: rtl/icache_direct_if.sv
// Line-fill bus between icache_direct and the line-wide instruction memory.
// master: cache side (issues line requests); slave: memory side (returns lines).
interface icache_direct_if #(
  parameter int LINE_WORDS = 4
);
  logic                     mem_req;
  logic [31:0]              mem_addr;
  logic                     mem_ready;
  logic [LINE_WORDS*32-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache in front of the fetch stage.
// The hit path is combinational from pc; a two-state FSM (IDLE/MISS) fetches a
// whole line on a miss and holds stall high until the line is resident.
// Optional macro ICACHE_PERF_EN adds saturating hit_count/miss_count outputs.
module icache_direct #(
  parameter int NUM_LINES  = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pipe_stall,
  input  logic        invalidate,
  output logic [31:0] instr,
  output logic        stall,
`ifdef ICACHE_PERF_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  icache_direct_if.master mem
);

  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int OFF_W  = WSEL_W + 2;
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                       state_q;
  logic                         mem_req_q;
  logic [31:0]                  mem_addr_q;
  logic [NUM_LINES-1:0]         valid_q;
  logic [TAG_W-1:0]             tag_q  [NUM_LINES];
  logic [LINE_WORDS-1:0][31:0]  data_q [NUM_LINES];

  logic [WSEL_W-1:0] pc_wsel;
  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic [31:0]       miss_addr_d;
  logic              hit;
  logic              fill_en;

  assign pc_wsel     = pc[OFF_W-1:2];
  assign pc_idx      = pc[OFF_W +: IDX_W];
  assign pc_tag      = pc[31 -: TAG_W];
  // The outstanding miss address doubles as the fill target.
  assign fill_idx    = mem_addr_q[OFF_W +: IDX_W];
  assign fill_tag    = mem_addr_q[31 -: TAG_W];
  assign fill_en     = (state_q == MISS) && mem.mem_ready;
  assign miss_addr_d = {pc[31:OFF_W], {OFF_W{1'b0}}};

  // Lookups are only honoured in IDLE so a redirect during a fill cannot hit stale state.
  assign hit   = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign stall = !hit;
  assign instr = hit ? data_q[pc_idx][pc_wsel] : NOP;

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

  // Miss FSM with registered request outputs; the address is frozen for the whole request.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hit) begin
            state_q    <= MISS;
            mem_req_q  <= 1'b1;
            mem_addr_q <= miss_addr_d;
          end
        end
        MISS: begin
          if (mem.mem_ready) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Valid bits: reset and invalidate both clear everything and override a same-edge fill.
  always_ff @(posedge clock) begin
    if (!reset || invalidate) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; a fill overwrites whatever line was resident.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem.mem_rdata;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Saturating performance counters: useful hits (fetch not held) and miss starts.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && !pipe_stall && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if ((state_q == IDLE) && !hit && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, pc[1:0]};
`else
  // Byte offset and the pipeline hold have no use without the counters.
  logic unused_ok;
  assign unused_ok = &{1'b0, pc[1:0], pipe_stall};
`endif

endmodule
